// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC core execution controller.
package npc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_EXEC,
    ST_WB,
    ST_HALT,
    ST_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] ERR_MISALIGN = 2'd3;

  localparam logic [31:0] RESET_PC    = 32'h8000_0000;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/npc_perf_cnt.sv
// Free-running performance counter with synchronous clear and count enable.
module npc_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/npc_exec_ctrl.sv
// Multi-cycle fetch/execute/writeback sequencer for the NPC core.
module npc_exec_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = npc_pkg::RESET_PC,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  output logic             imem_rsp_ready,
  input  logic [31:0]      imem_rsp_data,
  input  logic             dec_reg_wen,
  input  logic             dec_ebreak,
  input  logic             dec_illegal,
  input  logic [31:0]      dp_next_pc,
  output logic [31:0]      pc,
  output logic [31:0]      inst,
  output logic             rf_wen,
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  err_code_q, err_code_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    timer_d    = timer_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_FETCH_REQ: begin
        if (imem_req_ready) begin
          state_d = ST_FETCH_WAIT;
          timer_d = '0;
        end
      end
      ST_FETCH_WAIT: begin
        // A response arriving on the expiry cycle still wins over the trap.
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = ST_EXEC;
        end else if (timer_q == TIMER_LAST) begin
          state_d    = ST_ERR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_EXEC: begin
        if (dec_ebreak) begin
          state_d = ST_HALT;
        end else if (dec_illegal) begin
          state_d    = ST_ERR;
          err_code_d = ERR_ILLEGAL;
        end else if (dp_next_pc[1:0] != 2'b00) begin
          state_d    = ST_ERR;
          err_code_d = ERR_MISALIGN;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        pc_d    = dp_next_pc;
        state_d = ST_FETCH_REQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      timer_q    <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      timer_q    <= timer_d;
      err_code_q <= err_code_d;
    end
  end

  assign imem_req_valid = (state_q == ST_FETCH_REQ);
  assign imem_rsp_ready = (state_q == ST_FETCH_WAIT);
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign rf_wen         = (state_q == ST_WB) && dec_reg_wen;
  assign halted         = (state_q == ST_HALT);
  assign err            = (state_q == ST_ERR);
  assign err_code       = err_code_q;

  npc_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .clr (rst),
    .en  (!halted && !err),
    .cnt (cycle_cnt)
  );

  npc_perf_cnt #(.CNT_W(CNT_W)) u_instret_cnt (
    .clk (clk),
    .clr (rst),
    .en  (state_q == ST_WB),
    .cnt (instret_cnt)
  );

endmodule

// File: tb/tb_npc_exec_ctrl.sv
// Randomized program-level bench for npc_exec_ctrl with an in-bench memory, decoder and model.
module tb_npc_exec_ctrl;

  localparam int TMO = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_addr, rsp_data;
  logic        dec_reg_wen, dec_ebreak, dec_illegal;
  logic [31:0] dp_next_pc, pc, inst;
  logic        rf_wen, halted, err;
  logic [1:0]  err_code;
  logic [63:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  npc_exec_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TMO), .CNT_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (req_valid),
    .imem_req_ready (req_ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_ready (rsp_ready),
    .imem_rsp_data  (rsp_data),
    .dec_reg_wen    (dec_reg_wen),
    .dec_ebreak     (dec_ebreak),
    .dec_illegal    (dec_illegal),
    .dp_next_pc     (dp_next_pc),
    .pc             (pc),
    .inst           (inst),
    .rf_wen         (rf_wen),
    .halted         (halted),
    .err            (err),
    .err_code       (err_code),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
  );

  // Stand-in decoder/datapath: addi writes rd, opcode 6f jumps by imm[31:20], 7f is illegal.
  always_comb begin
    dec_ebreak  = (inst == 32'h0010_0073);
    dec_illegal = (inst[6:0] == 7'h7f);
    dec_reg_wen = (inst[6:0] == 7'h13) && (inst[11:7] != 5'd0);
    dp_next_pc  = (inst[6:0] == 7'h6f) ? pc + {{20{inst[31]}}, inst[31:20]} : pc + 32'd4;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] prog [16];

  function automatic logic [31:0] mk_addi();
    logic [4:0] rd;
    rd = 5'($urandom);
    return {12'($urandom), 5'($urandom), 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] mk_jump(input logic [11:0] off);
    return {off, 13'h0, 7'h6f};
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 64'(req_valid), 64'd1);
    chk("rst_rsp_ready", 64'(rsp_ready), 64'd0);
    chk("rst_pc", 64'(pc), 64'(RST_PC));
    chk("rst_inst", 64'(inst), 64'h13);
    chk("rst_err", 64'({halted, err, err_code, rf_wen}), 64'd0);
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_instret", instret_cnt, 64'd0);
    rst = 1'b0;
  endtask

  // term: 1 ebreak, 2 illegal, 3 misaligned next_pc, 4 fetch never answered.
  task automatic run_prog(input int n, input int term, input bit fast);
    logic [31:0] exp_addr [16];
    logic [31:0] pcm;
    logic [11:0] moff;
    int wen_exp, k, dly, idx, cyc_exp, wen_seen, acc_idx, stall;
    bit pending, done;
    logic [31:0] fz_pc, fz_inst;
    logic [63:0] fz_cyc, fz_ret;

    for (int i = 0; i < n - 1; i++)
      prog[i] = (!fast && ($urandom % 3 == 0)) ? mk_jump(12'(($urandom_range(0, 32) - 16) * 4))
                                               : mk_addi();
    case ($urandom % 3)
      0:       moff = 12'd6;
      1:       moff = 12'hffe;
      default: moff = 12'd10;
    endcase
    case (term)
      1:       prog[n-1] = 32'h0010_0073;
      2:       prog[n-1] = {25'($urandom), 7'h7f};
      3:       prog[n-1] = mk_jump(moff);
      default: prog[n-1] = mk_addi();
    endcase

    pcm = RST_PC; wen_exp = 0;
    for (int i = 0; i < n; i++) begin
      exp_addr[i] = pcm;
      if (i < n - 1) begin
        if (prog[i][6:0] == 7'h13) begin
          if (prog[i][11:7] != 5'd0) wen_exp++;
          pcm = pcm + 32'd4;
        end else begin
          pcm = pcm + {{20{prog[i][31]}}, prog[i][31:20]};
        end
      end
    end

    do_reset();
    k = 0; dly = 0; idx = 0; cyc_exp = 0; wen_seen = 0; acc_idx = -1; stall = 0;
    pending = 1'b0; done = 1'b0;
    while (!done) begin
      if (halted || err) begin
        done = 1'b1;
      end else if (idx > 2000) begin
        chk("run_bound", 64'(idx), 64'd0);
        done = 1'b1;
      end else begin
        cyc_exp++;
        if (rf_wen) wen_seen++;
        if (fast && idx == 8) chk("instret_at_8", instret_cnt, 64'd2);
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = $urandom;
        if (req_valid) begin
          if (!fast && k == 0 && stall < 5) begin
            chk("stall_addr", 64'(req_addr), 64'(RST_PC));
            chk("stall_rsp_ready", 64'(rsp_ready), 64'd0);
            rsp_valid = 1'($urandom);
            stall++;
          end else if (fast || ($urandom % 3 != 0)) begin
            req_ready = 1'b1;
            if (k < n) chk("fetch_addr", 64'(req_addr), 64'(exp_addr[k]));
            else       chk("extra_fetch", 64'(k), 64'(n - 1));
            if (fast) chk("fetch_spacing", 64'(idx), 64'(4 * k));
            dly = (term == 4 && k == n - 1) ? 100000 : (fast ? 0 : int'($urandom % TMO));
            pending = 1'b1; acc_idx = idx; k++;
          end
        end else if (rsp_ready && pending) begin
          if (dly == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = (k <= n) ? prog[k-1] : 32'h13;
            pending   = 1'b0;
          end else begin
            dly--;
          end
        end else if (!fast) begin
          rsp_valid = 1'($urandom);
        end
        idx++;
        @(negedge clk);
      end
    end

    if (term == 4) chk("timeout_latency", 64'(idx - acc_idx), 64'(TMO + 1));
    chk("halted", 64'(halted), 64'(term == 1));
    chk("err", 64'(err), 64'(term != 1));
    chk("err_code", 64'(err_code), (term == 1) ? 64'd0 : (term == 4) ? 64'd1 : (term == 2) ? 64'd2 : 64'd3);
    chk("final_pc", 64'(pc), 64'(pcm));
    chk("instret", instret_cnt, 64'(n - 1));
    chk("cycle_cnt", cycle_cnt, 64'(cyc_exp));
    chk("rf_wen_pulses", 64'(wen_seen), 64'(wen_exp));
    chk("fetches", 64'(k), 64'(n));

    fz_pc = pc; fz_inst = inst; fz_cyc = cycle_cnt; fz_ret = instret_cnt;
    for (int c = 0; c < 5; c++) begin
      req_ready = 1'($urandom); rsp_valid = 1'($urandom); rsp_data = $urandom;
      @(negedge clk);
      chk("frozen_outputs", 64'({req_valid, rsp_ready, rf_wen}), 64'd0);
    end
    chk("frozen_state", {fz_pc, fz_inst} ^ {pc, inst}, 64'd0);
    chk("frozen_cycle", cycle_cnt, fz_cyc);
    chk("frozen_instret", instret_cnt, fz_ret);
  endtask

  task automatic reset_mid_fetch();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_ready = req_valid;
      rsp_valid = rsp_ready;
      rsp_data  = 32'h0010_0093;
      if (c == 5) begin
        chk("pre_rst_pc", 64'(pc), 64'h8000_0004);
        chk("pre_rst_wait", 64'(rsp_ready), 64'd1);
        chk("pre_rst_instret", instret_cnt, 64'd1);
        rsp_valid = 1'b0;
        rst = 1'b1;
      end
      @(negedge clk);
    end
    chk("mid_rst_req_valid", 64'(req_valid), 64'd1);
    chk("mid_rst_rsp_ready", 64'(rsp_ready), 64'd0);
    chk("mid_rst_pc", 64'(pc), 64'(RST_PC));
    chk("mid_rst_inst", 64'(inst), 64'h13);
    chk("mid_rst_counters", cycle_cnt | instret_cnt, 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    run_prog(3, 1, 1'b1);
    for (int r = 0; r < 12; r++) run_prog($urandom_range(1, 8), (r % 4) + 1, 1'b0);
    reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
